serial_deserializer: RTL
========================

# serial_deserializer

- Receive side of the serial link: rebuilds WIDTH-bit words from the single-bit stream that the serial interface shifts out of its FIFO.
- Checks framing and even parity on each word.
- Pushes each good word into the receive-side FIFO, and holds it there while the FIFO is full.
- Sits between the serial pins and the receive FIFO write port, in the s_clk domain.

## Interface

- WIDTH, 8, data bits per frame; must be ≥ 2. Bit counter width is $clog2(WIDTH).

- s_clk  input  1  serial clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  qualifies sin for the current cycle (transmitter req).
- fifo_full  input  1  receive FIFO full flag.
- data_out  output  WIDTH  received word; valid while push=1.
- push  output  1  one-cycle write strobe to the FIFO.
- parity_err  output  1  one-cycle pulse: parity mismatch, frame dropped.
- frame_err  output  1  one-cycle pulse: sin_valid dropped mid-frame, frame dropped.
- overrun_err  output  1  one-cycle pulse: start bit arrived while in HOLD, frame dropped.
- state  output  2  current FSM state, for debug.

## Operation

- Frame format, one bit per cycle with sin_valid=1 for every bit:
  - start bit (sin=1);
  - WIDTH data bits, MSB first;
  - one even-parity bit, equal to the XOR of the data bits.
- IDLE (00):
  - sin_valid=1 and sin=1 → SHIFT; clear the bit counter.
  - All other inputs are ignored.
- SHIFT (01):
  - Each cycle with sin_valid=1: shift_reg <= {shift_reg[WIDTH-2:0], sin}; counter increments.
  - After the bit with counter = WIDTH-1 is sampled → PARITY.
  - sin_valid=0 → frame_err pulse, → IDLE, partial word discarded.
- PARITY (10), sample the parity bit:
  - sin_valid=0 → frame_err pulse, → IDLE.
  - sin != ^shift_reg → parity_err pulse, → IDLE; nothing pushed.
  - Match and fifo_full=0 → data_out <= shift_reg, push <= 1, → IDLE.
  - Match and fifo_full=1 → data_out <= shift_reg, → HOLD.
- HOLD (11):
  - data_out is held stable.
  - When fifo_full=0 → push <= 1, → IDLE.
  - A start bit (sin_valid=1, sin=1) seen in HOLD → overrun_err pulse. The incoming frame is dropped and the state stays HOLD; the held word is kept.
- push, parity_err, frame_err and overrun_err are registered. Each is high for exactly one cycle per event and never high in the same cycle as another of these pulses.
- data_out holds its last value when push=0.

## Timing

- Reset (async assert, sync release):
  - state = IDLE;
  - shift_reg, counter and data_out = 0;
  - push and all error outputs = 0.
- Reset asserted mid-frame aborts the frame immediately and generates no pulse of any kind.
- Latency, with the start bit sampled at edge 0:
  - data bits at edges 1..WIDTH;
  - parity bit at edge WIDTH+1;
  - push=1 during the cycle after edge WIDTH+1.
  - For WIDTH=8: push is high in the cycle after edge 9.
- Back-to-back frames:
  - The next start bit may be sampled at edge WIDTH+2, in the same cycle that push is high.
  - Sustained throughput is one word per WIDTH+2 cycles.
- HOLD release: push rises in the cycle after the edge that samples fifo_full=0.
- Simultaneous start bit and fifo_full=0 in HOLD:
  - the held word is pushed and the state goes to IDLE;
  - the start bit is dropped, and overrun_err pulses.
- In SHIFT, sin=1 is treated as a data bit, never as a new start bit.

## Test plan

- Reset:
  - Assert rst mid-SHIFT → all outputs 0 and state=00 asynchronously.
  - Release rst and send 0xA5 with parity 0 → push with data_out=0xA5 in the cycle after edge 9.
- Parity:
  - Send 0x07 with parity 1 → push with data_out=0x07.
  - Send 0x07 with parity 0 → parity_err pulses once, no push, state=00.
- Back-to-back: frames 0x3C then 0xC3 with no gap cycle → two pushes exactly 10 cycles apart, with data_out = 0x3C then 0xC3.
- Framing: drop sin_valid after the 4th data bit → frame_err pulses once; the next good frame 0x55 is received correctly.
- FIFO full:
  - fifo_full=1 while frame 0x81 completes → state=11, no push.
  - Release fifo_full 5 cycles later → push with data_out=0x81 one cycle later.
- Overrun: during HOLD, send a start bit → overrun_err pulses once and the held 0x81 is still pushed on release.

Source files
------------

// File: rtl/serial_deserializer.sv
// serial_deserializer: receive side of the serial link.
// Rebuilds WIDTH-bit words (start bit, MSB-first data, even parity) from a
// qualified bit stream, checks framing/parity, and pushes good words into
// the receive FIFO, holding the word while the FIFO reports full.
module serial_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             s_clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             fifo_full,
   output logic [WIDTH-1:0] data_out,
   output logic             push,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun_err,
   output logic [1:0]       state
);

   localparam int CW = $clog2(WIDTH);
   // Drop counter must reach WIDTH (data bits plus parity after the start bit)
   localparam int DW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_SHIFT  = 2'b01,
      S_PARITY = 2'b10,
      S_HOLD   = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             push_q, push_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             oerr_q, oerr_d;
   // Overrun seen on the same edge as a HOLD release: the push goes out
   // first and the overrun pulse follows one cycle later, so no two
   // strobes ever share a cycle.
   logic             ovr_pend_q, ovr_pend_d;
   // Remainder of an overrun frame is swallowed so its data bits are not
   // mistaken for start bits once the block is back in IDLE/HOLD.
   logic             drop_q, drop_d;
   logic [DW-1:0]    dcnt_q, dcnt_d;

   logic start;
   logic last_bit;
   logic par_ok;

   assign start    = sin_valid & sin & ~drop_q;
   assign last_bit = (cnt_q == CW'(WIDTH - 1));
   assign par_ok   = (sin == ^shift_q);

   // State register
   always_ff @(posedge s_clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_SHIFT;
         S_SHIFT: begin
            if (!sin_valid)    state_d = S_IDLE;
            else if (last_bit) state_d = S_PARITY;
         end
         S_PARITY: begin
            if (sin_valid && par_ok && fifo_full) state_d = S_HOLD;
            else                                  state_d = S_IDLE;
         end
         S_HOLD:   if (!fifo_full) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath and strobe next-values per state
   always_comb begin
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      push_d     = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      oerr_d     = ovr_pend_q;
      ovr_pend_d = 1'b0;
      drop_d     = drop_q;
      dcnt_d     = dcnt_q;

      if (state_q == S_HOLD && start) begin
         drop_d = 1'b1;
         dcnt_d = '0;
      end else if (drop_q) begin
         if (!sin_valid)                drop_d = 1'b0;
         else if (dcnt_q == DW'(WIDTH)) drop_d = 1'b0;
         else                           dcnt_d = dcnt_q + DW'(1);
      end

      case (state_q)
         S_IDLE: if (start) cnt_d = '0;
         S_SHIFT: begin
            if (sin_valid) begin
               shift_d = {shift_q[WIDTH-2:0], sin};
               cnt_d   = cnt_q + CW'(1);
            end else begin
               ferr_d = 1'b1;
            end
         end
         S_PARITY: begin
            if (!sin_valid)   ferr_d = 1'b1;
            else if (!par_ok) perr_d = 1'b1;
            else begin
               data_d = shift_q;
               push_d = ~fifo_full;
            end
         end
         S_HOLD: begin
            if (!fifo_full) begin
               push_d     = 1'b1;
               ovr_pend_d = start;
            end else if (start) begin
               oerr_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge s_clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         push_q     <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         oerr_q     <= 1'b0;
         ovr_pend_q <= 1'b0;
         drop_q     <= 1'b0;
         dcnt_q     <= '0;
      end else begin
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         push_q     <= push_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         oerr_q     <= oerr_d;
         ovr_pend_q <= ovr_pend_d;
         drop_q     <= drop_d;
         dcnt_q     <= dcnt_d;
      end
   end

   assign data_out    = data_q;
   assign push        = push_q;
   assign parity_err  = perr_q;
   assign frame_err   = ferr_q;
   assign overrun_err = oerr_q;
   assign state       = state_q;

endmodule
